bp_fe_icache_miss_responder: RTL and testbench

LCE-side responder for the FE I-cache service interface. It accepts cache_req/cache_req_metadata from the FE and fetches the missing block from a beat-serial backing memory port. It then writes the block back into the I-cache through data/tag/stat mem packets and pulses cache_req_complete. It serves as a lightweight stand-in for a full coherent LCE in FE-only testbenches and in cache-coherence-free configurations.

---
 rtl/bp_fe_icache_miss_responder_pkg.sv | 102 ++++++++++
 rtl/bp_fe_icache_miss_responder_block_deserializer.sv | 48 ++++
 rtl/bp_fe_icache_miss_responder.sv | 202 ++++++++++++++++++++
 tb/tb_bp_fe_icache_miss_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_icache_miss_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_icache_miss_responder_pkg
// Brief    : Cache-service message formats, mem packet opcodes and responder
//            FSM state encoding shared by the FE miss responder and its users.
// Revision : 1.0 - initial release
// ============================================================================
package bp_fe_icache_miss_responder_pkg;

    localparam int c_paddr_width = 40;
    localparam int c_dword_width = 64;
    localparam int c_block_width = 512;
    localparam int c_block_beats = c_block_width / c_dword_width;
    localparam int c_index_width = 6;
    localparam int c_way_width   = 3;
    localparam int c_ptag_width  = 28;

    typedef enum logic [3:0] {
        e_miss_store = 4'd0,
        e_miss_load  = 4'd1,
        e_uc_store   = 4'd2,
        e_uc_load    = 4'd3,
        e_wt_store   = 4'd4
    } bp_cache_req_msg_type_e;

    typedef enum logic [1:0] {
        e_cache_data_mem_read     = 2'd0,
        e_cache_data_mem_write    = 2'd1,
        e_cache_data_mem_uncached = 2'd2
    } bp_cache_data_mem_opcode_e;

    typedef enum logic [1:0] {
        e_cache_tag_mem_set_clear  = 2'd0,
        e_cache_tag_mem_set_tag    = 2'd1,
        e_cache_tag_mem_invalidate = 2'd2
    } bp_cache_tag_mem_opcode_e;

    typedef enum logic [1:0] {
        e_cache_stat_mem_set_clear   = 2'd0,
        e_cache_stat_mem_read        = 2'd1,
        e_cache_stat_mem_clear_dirty = 2'd2
    } bp_cache_stat_mem_opcode_e;

    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_M = 3'd3
    } bp_coh_states_e;

    typedef enum logic [2:0] {
        e_ready     = 3'd0,
        e_wait_meta = 3'd1,
        e_mem_cmd   = 3'd2,
        e_mem_resp  = 3'd3,
        e_wr_data   = 3'd4,
        e_wr_tag    = 3'd5,
        e_wr_stat   = 3'd6,
        e_done      = 3'd7
    } bp_fe_miss_resp_state_e;

    typedef struct packed {
        bp_cache_req_msg_type_e      msg_type;
        logic [c_paddr_width-1:0]    addr;
        logic [1:0]                  size;
        logic [c_dword_width-1:0]    data;
    } bp_cache_req_s;

    typedef struct packed {
        logic [c_way_width-1:0]      repl_way;
        logic                        dirty;
    } bp_cache_req_metadata_s;

    typedef struct packed {
        bp_cache_data_mem_opcode_e   opcode;
        logic [c_index_width-1:0]    index;
        logic [c_way_width-1:0]      way_id;
        logic [c_block_width-1:0]    data;
    } bp_cache_data_mem_pkt_s;

    typedef struct packed {
        bp_cache_tag_mem_opcode_e    opcode;
        logic [c_index_width-1:0]    index;
        logic [c_way_width-1:0]      way_id;
        bp_coh_states_e              state;
        logic [c_ptag_width-1:0]     tag;
    } bp_cache_tag_mem_pkt_s;

    typedef struct packed {
        bp_cache_stat_mem_opcode_e   opcode;
        logic [c_index_width-1:0]    index;
        logic [c_way_width-1:0]      way_id;
    } bp_cache_stat_mem_pkt_s;

    localparam int c_cache_req_width          = $bits(bp_cache_req_s);
    localparam int c_cache_req_metadata_width = $bits(bp_cache_req_metadata_s);
    localparam int c_data_mem_pkt_width       = $bits(bp_cache_data_mem_pkt_s);
    localparam int c_tag_mem_pkt_width        = $bits(bp_cache_tag_mem_pkt_s);
    localparam int c_stat_mem_pkt_width       = $bits(bp_cache_stat_mem_pkt_s);

endpackage
`default_nettype wire

// File: rtl/bp_fe_icache_miss_responder_block_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_block_deserializer
// Brief    : Collects memory beats into a cache block by beat index.
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_block_deserializer #(
    parameter int DWORD_WIDTH = 64,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_v,
    input  logic [DWORD_WIDTH-1:0]  beat_data,
    input  logic [((BLOCK_WIDTH/DWORD_WIDTH) > 1 ? $clog2(BLOCK_WIDTH/DWORD_WIDTH) : 1)-1:0] last_index,
    output logic [BLOCK_WIDTH-1:0]  block,
    output logic                    last_beat
);
    localparam int c_beats      = BLOCK_WIDTH / DWORD_WIDTH;
    localparam int c_count_bits = (c_beats > 1) ? $clog2(c_beats) : 1;

    logic [c_count_bits-1:0] r_count;
    logic [DWORD_WIDTH-1:0]  r_beats [c_beats];

    assign last_beat = (r_count == last_index);

    // Counter wraps after the final beat so the next fill starts at beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (beat_v) begin
            r_count <= last_beat ? '0 : r_count + 1'b1;
        end
    end

    for (genvar g = 0; g < c_beats; g++) begin : g_beat
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_beats[g] <= '0;
            end else if (beat_v && (r_count == c_count_bits'(g))) begin
                r_beats[g] <= beat_data;
            end
        end
        assign block[g*DWORD_WIDTH +: DWORD_WIDTH] = r_beats[g];
    end

endmodule
`default_nettype wire

// File: rtl/bp_fe_icache_miss_responder.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_icache_miss_responder
// Brief    : FE I-cache miss responder: fetches a block (or one uncached
//            dword) from beat-serial memory and writes it into the I-cache.
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_icache_miss_responder
    import bp_fe_icache_miss_responder_pkg::*;
#(
    parameter int PADDR_WIDTH     = 40,
    parameter int DWORD_WIDTH     = 64,
    parameter int CCE_BLOCK_WIDTH = 512,
    parameter int LCE_SETS        = 64,
    parameter int LCE_ASSOC       = 8,
    parameter int PTAG_WIDTH      = 28
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [c_cache_req_width-1:0]          cache_req_i,
    input  logic                                  cache_req_v_i,
    output logic                                  cache_req_ready_o,
    input  logic [c_cache_req_metadata_width-1:0] cache_req_metadata_i,
    input  logic                                  cache_req_metadata_v_i,
    output logic                                  cache_req_complete_o,
    output logic [c_data_mem_pkt_width-1:0]       data_mem_pkt_o,
    output logic                                  data_mem_pkt_v_o,
    input  logic                                  data_mem_pkt_yumi_i,
    output logic [c_tag_mem_pkt_width-1:0]        tag_mem_pkt_o,
    output logic                                  tag_mem_pkt_v_o,
    input  logic                                  tag_mem_pkt_yumi_i,
    output logic [c_stat_mem_pkt_width-1:0]       stat_mem_pkt_o,
    output logic                                  stat_mem_pkt_v_o,
    input  logic                                  stat_mem_pkt_yumi_i,
    output logic [PADDR_WIDTH-1:0]                mem_cmd_addr_o,
    output logic                                  mem_cmd_v_o,
    input  logic                                  mem_cmd_ready_i,
    input  logic [DWORD_WIDTH-1:0]                mem_resp_data_i,
    input  logic                                  mem_resp_v_i,
    output logic                                  mem_resp_yumi_o
);
    localparam int c_beat_count        = CCE_BLOCK_WIDTH / DWORD_WIDTH;
    localparam int c_offset_bits       = $clog2(CCE_BLOCK_WIDTH / 8);
    localparam int c_dword_offset_bits = $clog2(DWORD_WIDTH / 8);
    localparam int c_set_bits          = $clog2(LCE_SETS);
    localparam int c_way_bits          = $clog2(LCE_ASSOC);
    localparam int c_count_bits        = (c_beat_count > 1) ? $clog2(c_beat_count) : 1;

    bp_fe_miss_resp_state_e  r_state, w_state_next;
    logic [PADDR_WIDTH-1:0]  r_addr;
    logic                    r_uncached;
    logic [c_way_bits-1:0]   r_way;

    bp_cache_req_s           w_req;
    bp_cache_req_metadata_s  w_meta;
    bp_cache_data_mem_pkt_s  w_data_pkt;
    bp_cache_tag_mem_pkt_s   w_tag_pkt;
    bp_cache_stat_mem_pkt_s  w_stat_pkt;
    logic                    w_req_fire;
    logic                    w_req_miss;
    logic                    w_req_uncached;
    logic                    w_last_beat;
    logic [c_count_bits-1:0] w_last_index;
    logic [CCE_BLOCK_WIDTH-1:0] w_block;
    logic [c_set_bits-1:0]   w_index;
    logic                    w_unused_req_bits;

    assign w_req  = bp_cache_req_s'(cache_req_i);
    assign w_meta = bp_cache_req_metadata_s'(cache_req_metadata_i);
    assign w_unused_req_bits = ^{w_req.size, w_req.data, w_meta.dirty};

    assign cache_req_ready_o = (r_state == e_ready) && !reset_i;
    assign w_req_fire        = cache_req_v_i && cache_req_ready_o;
    assign w_req_miss        = (w_req.msg_type == e_miss_load);
    assign w_req_uncached    = (w_req.msg_type == e_uc_load);
    assign mem_resp_yumi_o   = (r_state == e_mem_resp) && mem_resp_v_i;
    assign w_last_index      = r_uncached ? '0 : c_count_bits'(c_beat_count - 1);
    assign w_index           = r_addr[c_offset_bits +: c_set_bits];

    bp_fe_block_deserializer #(
        .DWORD_WIDTH (DWORD_WIDTH),
        .BLOCK_WIDTH (CCE_BLOCK_WIDTH)
    ) u_deserializer (
        .clk        (clk_i),
        .rst        (reset_i),
        .beat_v     (mem_resp_yumi_o),
        .beat_data  (mem_resp_data_i),
        .last_index (w_last_index),
        .block      (w_block),
        .last_beat  (w_last_beat)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_ready;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Way may arrive with the request itself or later while waiting.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_addr     <= '0;
            r_uncached <= 1'b0;
            r_way      <= '0;
        end else begin
            if (w_req_fire) begin
                r_addr     <= w_req.addr;
                r_uncached <= w_req_uncached;
            end
            if (cache_req_metadata_v_i
                && ((w_req_fire && w_req_miss) || (r_state == e_wait_meta))) begin
                r_way <= w_meta.repl_way;
            end
        end
    end

    always_comb begin
        w_state_next         = r_state;
        mem_cmd_v_o          = 1'b0;
        data_mem_pkt_v_o     = 1'b0;
        tag_mem_pkt_v_o      = 1'b0;
        stat_mem_pkt_v_o     = 1'b0;
        cache_req_complete_o = 1'b0;
        case (r_state)
            e_ready: begin
                if (w_req_fire) begin
                    if (w_req_uncached) begin
                        w_state_next = e_mem_cmd;
                    end else if (w_req_miss) begin
                        w_state_next = cache_req_metadata_v_i ? e_mem_cmd : e_wait_meta;
                    end else begin
                        w_state_next = e_done;
                    end
                end
            end
            e_wait_meta: begin
                if (cache_req_metadata_v_i) w_state_next = e_mem_cmd;
            end
            e_mem_cmd: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) w_state_next = e_mem_resp;
            end
            e_mem_resp: begin
                if (mem_resp_v_i && w_last_beat) w_state_next = e_wr_data;
            end
            e_wr_data: begin
                data_mem_pkt_v_o = 1'b1;
                if (data_mem_pkt_yumi_i) w_state_next = r_uncached ? e_done : e_wr_tag;
            end
            e_wr_tag: begin
                tag_mem_pkt_v_o = 1'b1;
                if (tag_mem_pkt_yumi_i) w_state_next = e_wr_stat;
            end
            e_wr_stat: begin
                stat_mem_pkt_v_o = 1'b1;
                if (stat_mem_pkt_yumi_i) w_state_next = e_done;
            end
            e_done: begin
                cache_req_complete_o = 1'b1;
                w_state_next         = e_ready;
            end
            default: w_state_next = e_ready;
        endcase
    end

    always_comb begin
        mem_cmd_addr_o = r_uncached
            ? {r_addr[PADDR_WIDTH-1:c_dword_offset_bits], {c_dword_offset_bits{1'b0}}}
            : {r_addr[PADDR_WIDTH-1:c_offset_bits], {c_offset_bits{1'b0}}};

        w_data_pkt        = '0;
        w_data_pkt.index  = w_index;
        w_data_pkt.way_id = r_way;
        if (r_uncached) begin
            w_data_pkt.opcode = e_cache_data_mem_uncached;
            w_data_pkt.data   = {c_beat_count{w_block[DWORD_WIDTH-1:0]}};
        end else begin
            w_data_pkt.opcode = e_cache_data_mem_write;
            w_data_pkt.data   = w_block;
        end

        w_tag_pkt        = '0;
        w_tag_pkt.opcode = e_cache_tag_mem_set_tag;
        w_tag_pkt.index  = w_index;
        w_tag_pkt.way_id = r_way;
        w_tag_pkt.state  = e_COH_S;
        w_tag_pkt.tag    = r_addr[PADDR_WIDTH-1 -: PTAG_WIDTH];

        w_stat_pkt        = '0;
        w_stat_pkt.opcode = e_cache_stat_mem_set_clear;
        w_stat_pkt.index  = w_index;
        w_stat_pkt.way_id = r_way;
    end

    assign data_mem_pkt_o = w_data_pkt;
    assign tag_mem_pkt_o  = w_tag_pkt;
    assign stat_mem_pkt_o = w_stat_pkt;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_icache_miss_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_icache_miss_responder
// Brief    : Directed, table-driven self-checking bench for the miss responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fe_icache_miss_responder;
    import bp_fe_icache_miss_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                  reset_i;
    logic [c_cache_req_width-1:0]          cache_req_i;
    logic                                  cache_req_v_i;
    logic                                  cache_req_ready_o;
    logic [c_cache_req_metadata_width-1:0] cache_req_metadata_i;
    logic                                  cache_req_metadata_v_i;
    logic                                  cache_req_complete_o;
    logic [c_data_mem_pkt_width-1:0]       data_mem_pkt_o;
    logic                                  data_mem_pkt_v_o;
    logic                                  data_mem_pkt_yumi_i;
    logic [c_tag_mem_pkt_width-1:0]        tag_mem_pkt_o;
    logic                                  tag_mem_pkt_v_o;
    logic                                  tag_mem_pkt_yumi_i;
    logic [c_stat_mem_pkt_width-1:0]       stat_mem_pkt_o;
    logic                                  stat_mem_pkt_v_o;
    logic                                  stat_mem_pkt_yumi_i;
    logic [c_paddr_width-1:0]              mem_cmd_addr_o;
    logic                                  mem_cmd_v_o;
    logic                                  mem_cmd_ready_i;
    logic [c_dword_width-1:0]              mem_resp_data_i;
    logic                                  mem_resp_v_i;
    logic                                  mem_resp_yumi_o;

    bp_fe_icache_miss_responder dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .cache_req_i            (cache_req_i),
        .cache_req_v_i          (cache_req_v_i),
        .cache_req_ready_o      (cache_req_ready_o),
        .cache_req_metadata_i   (cache_req_metadata_i),
        .cache_req_metadata_v_i (cache_req_metadata_v_i),
        .cache_req_complete_o   (cache_req_complete_o),
        .data_mem_pkt_o         (data_mem_pkt_o),
        .data_mem_pkt_v_o       (data_mem_pkt_v_o),
        .data_mem_pkt_yumi_i    (data_mem_pkt_yumi_i),
        .tag_mem_pkt_o          (tag_mem_pkt_o),
        .tag_mem_pkt_v_o        (tag_mem_pkt_v_o),
        .tag_mem_pkt_yumi_i     (tag_mem_pkt_yumi_i),
        .stat_mem_pkt_o         (stat_mem_pkt_o),
        .stat_mem_pkt_v_o       (stat_mem_pkt_v_o),
        .stat_mem_pkt_yumi_i    (stat_mem_pkt_yumi_i),
        .mem_cmd_addr_o         (mem_cmd_addr_o),
        .mem_cmd_v_o            (mem_cmd_v_o),
        .mem_cmd_ready_i        (mem_cmd_ready_i),
        .mem_resp_data_i        (mem_resp_data_i),
        .mem_resp_v_i           (mem_resp_v_i),
        .mem_resp_yumi_o        (mem_resp_yumi_o)
    );

    typedef struct {
        string                   name;
        bp_cache_req_msg_type_e  msg;
        logic [c_paddr_width-1:0] addr;
        int                      meta_delay;
        logic [c_way_width-1:0]  way;
        logic [c_dword_width-1:0] base;
        int                      tag_stall;
        bit                      expect_mem;
        bit                      uncached;
        logic [c_paddr_width-1:0] exp_cmd_addr;
        int                      exp_cmd_cycle;
        logic [c_index_width-1:0] exp_index;
        logic [c_ptag_width-1:0] exp_tag;
        int                      exp_done;
    } vec_t;

    vec_t vecs [8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        cache_req_v_i          = 1'b0;
        cache_req_metadata_v_i = 1'b0;
        mem_resp_v_i           = 1'b0;
        mem_cmd_ready_i        = 1'b1;
        data_mem_pkt_yumi_i    = 1'b1;
        tag_mem_pkt_yumi_i     = 1'b1;
        stat_mem_pkt_yumi_i    = 1'b1;
    endtask

    function automatic logic [6:0] all_outputs_v();
        return {cache_req_ready_o, cache_req_complete_o, mem_cmd_v_o, data_mem_pkt_v_o,
                tag_mem_pkt_v_o, stat_mem_pkt_v_o, mem_resp_yumi_o};
    endfunction

    // Called at posedge+1; returns at posedge+1. Cycle 0 is the accept cycle.
    task automatic run_txn(input vec_t v);
        bp_cache_req_s          req;
        bp_cache_req_metadata_s meta;
        bp_cache_data_mem_pkt_s dpkt;
        bp_cache_tag_mem_pkt_s  tpkt, tfirst;
        bp_cache_stat_mem_pkt_s spkt;
        logic [c_block_width-1:0] exp_block;
        logic [c_paddr_width-1:0] cmd_addr = '0;
        int  beats_needed = v.uncached ? 1 : c_block_beats;
        int  beats_sent = 0, cmd_cycle = -1, cmd_count = 0, done_cycle = -1;
        int  data_seen = 0, tag_seen = 0, stat_seen = 0, tag_stalled = 0, tag_cycles = 0;
        bit  cmd_done = 0, tag_stable = 1, stat_early = 0;

        dpkt = '0; tpkt = '0; tfirst = '0; spkt = '0;
        req = '0;
        req.msg_type = v.msg;
        req.addr     = v.addr;
        meta.repl_way = v.way;
        meta.dirty    = 1'b0;
        for (int k = 0; k < c_block_beats; k++)
            exp_block[k*c_dword_width +: c_dword_width] = v.uncached ? v.base : v.base + 64'(k);

        for (int c = 0; c < 80 && done_cycle < 0; c++) begin
            cache_req_i            = req;
            cache_req_v_i          = (c == 0);
            cache_req_metadata_i   = meta;
            cache_req_metadata_v_i = (c == v.meta_delay);
            mem_cmd_ready_i        = 1'b1;
            mem_resp_v_i           = cmd_done && (beats_sent < beats_needed);
            mem_resp_data_i        = v.base + 64'(beats_sent);
            data_mem_pkt_yumi_i    = 1'b1;
            stat_mem_pkt_yumi_i    = 1'b1;
            tag_mem_pkt_yumi_i     = (tag_stalled >= v.tag_stall);
            #1;
            if (c == 0) chk({v.name, " ready"}, cache_req_ready_o, 1'b1);
            if (mem_cmd_v_o) begin
                if (cmd_cycle < 0) begin
                    cmd_cycle = c;
                    cmd_addr  = mem_cmd_addr_o;
                end
                cmd_count++;
                cmd_done = 1;
            end
            if (mem_resp_yumi_o) beats_sent++;
            if (data_mem_pkt_v_o) begin
                dpkt = data_mem_pkt_o;
                data_seen++;
            end
            if (tag_mem_pkt_v_o) begin
                tpkt = tag_mem_pkt_o;
                if (tag_cycles == 0) tfirst = tpkt;
                else if (tpkt !== tfirst) tag_stable = 0;
                tag_cycles++;
                if (stat_mem_pkt_v_o) stat_early = 1;
                if (tag_mem_pkt_yumi_i) tag_seen++;
                else tag_stalled++;
            end
            if (stat_mem_pkt_v_o) begin
                spkt = stat_mem_pkt_o;
                stat_seen++;
            end
            if (cache_req_complete_o) done_cycle = c;
            @(posedge clk); #1;
        end

        idle_inputs();
        #1;
        chk({v.name, " complete_one_cycle"}, cache_req_complete_o, 1'b0);
        chk({v.name, " ready_after"}, cache_req_ready_o, 1'b1);

        chk({v.name, " done_cycle"}, done_cycle, v.exp_done);
        chk({v.name, " cmd_count"}, cmd_count, v.expect_mem ? 1 : 0);
        chk({v.name, " data_count"}, data_seen, v.expect_mem ? 1 : 0);
        chk({v.name, " tag_count"}, tag_seen, (v.expect_mem && !v.uncached) ? 1 : 0);
        chk({v.name, " stat_count"}, stat_seen, (v.expect_mem && !v.uncached) ? 1 : 0);
        if (v.expect_mem) begin
            chk({v.name, " cmd_cycle"}, cmd_cycle, v.exp_cmd_cycle);
            chk({v.name, " cmd_addr"}, cmd_addr, v.exp_cmd_addr);
            chk({v.name, " data_opcode"}, dpkt.opcode,
                v.uncached ? e_cache_data_mem_uncached : e_cache_data_mem_write);
            chk({v.name, " data_index"}, dpkt.index, v.exp_index);
            chk({v.name, " data_block"}, dpkt.data, exp_block);
        end
        if (v.expect_mem && !v.uncached) begin
            chk({v.name, " data_way"}, dpkt.way_id, v.way);
            chk({v.name, " tag_pkt"}, {tpkt.opcode, tpkt.index, tpkt.way_id, tpkt.state, tpkt.tag},
                {e_cache_tag_mem_set_tag, v.exp_index, v.way, e_COH_S, v.exp_tag});
            chk({v.name, " stat_pkt"}, {spkt.opcode, spkt.index, spkt.way_id},
                {e_cache_stat_mem_set_clear, v.exp_index, v.way});
            chk({v.name, " tag_stable"}, tag_stable, 1'b1);
            chk({v.name, " stat_during_tag"}, stat_early, 1'b0);
            chk({v.name, " tag_valid_cycles"}, tag_cycles, v.tag_stall + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bp_cache_req_s req;
        int beats;
        bit cmd_done;

        vecs[0] = '{name:"miss_direct", msg:e_miss_load, addr:40'h00_8000_1234, meta_delay:0,
                    way:3'd5, base:64'h0, tag_stall:0, expect_mem:1, uncached:0,
                    exp_cmd_addr:40'h00_8000_1200, exp_cmd_cycle:1, exp_index:6'd8,
                    exp_tag:28'h0080001, exp_done:13};
        vecs[1] = '{name:"miss_meta_late", msg:e_miss_load, addr:40'h12_3456_7FC0, meta_delay:4,
                    way:3'd2, base:64'h100, tag_stall:0, expect_mem:1, uncached:0,
                    exp_cmd_addr:40'h12_3456_7FC0, exp_cmd_cycle:5, exp_index:6'd63,
                    exp_tag:28'h1234567, exp_done:17};
        vecs[2] = '{name:"uc_load", msg:e_uc_load, addr:40'h00_0000_1008, meta_delay:99,
                    way:3'd0, base:64'hDEADBEEF, tag_stall:0, expect_mem:1, uncached:1,
                    exp_cmd_addr:40'h00_0000_1008, exp_cmd_cycle:1, exp_index:6'd0,
                    exp_tag:28'h0, exp_done:4};
        vecs[3] = '{name:"uc_load_unaligned", msg:e_uc_load, addr:40'h20_0000_0FFF, meta_delay:99,
                    way:3'd0, base:64'h0123_4567_89AB_CDEF, tag_stall:0, expect_mem:1, uncached:1,
                    exp_cmd_addr:40'h20_0000_0FF8, exp_cmd_cycle:1, exp_index:6'd63,
                    exp_tag:28'h0, exp_done:4};
        vecs[4] = '{name:"miss_store_drop", msg:e_miss_store, addr:40'h00_0000_4000, meta_delay:0,
                    way:3'd1, base:64'h0, tag_stall:0, expect_mem:0, uncached:0,
                    exp_cmd_addr:40'h0, exp_cmd_cycle:0, exp_index:6'd0,
                    exp_tag:28'h0, exp_done:1};
        vecs[5] = '{name:"tag_backpressure", msg:e_miss_load, addr:40'h00_8000_1234, meta_delay:0,
                    way:3'd3, base:64'h1000, tag_stall:5, expect_mem:1, uncached:0,
                    exp_cmd_addr:40'h00_8000_1200, exp_cmd_cycle:1, exp_index:6'd8,
                    exp_tag:28'h0080001, exp_done:18};
        vecs[6] = '{name:"miss_all_ones", msg:e_miss_load, addr:40'hFF_FFFF_FFFF, meta_delay:0,
                    way:3'd7, base:64'hA5A5_0000_0000_0000, tag_stall:0, expect_mem:1, uncached:0,
                    exp_cmd_addr:40'hFF_FFFF_FFC0, exp_cmd_cycle:1, exp_index:6'd63,
                    exp_tag:28'hFFF_FFFF, exp_done:13};
        vecs[7] = '{name:"uc_store_drop", msg:e_uc_store, addr:40'h00_0000_0008, meta_delay:99,
                    way:3'd0, base:64'h0, tag_stall:0, expect_mem:0, uncached:0,
                    exp_cmd_addr:40'h0, exp_cmd_cycle:0, exp_index:6'd0,
                    exp_tag:28'h0, exp_done:1};

        reset_i              = 1'b1;
        cache_req_i          = '0;
        cache_req_metadata_i = '0;
        mem_resp_data_i      = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outputs_v(), 7'b0);
        reset_i = 1'b0;
        #1;
        chk("ready_after_reset", cache_req_ready_o, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Abandon a fill after four beats with an asynchronous reset.
        req = '0;
        req.msg_type = e_miss_load;
        req.addr     = 40'h00_8000_1234;
        cache_req_i          = req;
        cache_req_metadata_i = {3'd5, 1'b0};
        beats    = 0;
        cmd_done = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            cache_req_v_i          = (c == 0);
            cache_req_metadata_v_i = (c == 0);
            mem_resp_v_i           = cmd_done;
            mem_resp_data_i        = 64'h55 + 64'(beats);
            #1;
            if (mem_cmd_v_o) cmd_done = 1;
            if (mem_resp_yumi_o) beats++;
            @(posedge clk); #1;
        end
        chk("midfill_beats", beats, 4);
        cache_req_v_i          = 1'b0;
        cache_req_metadata_v_i = 1'b0;
        mem_resp_v_i           = 1'b1;
        #1;
        chk("midfill_yumi_before_reset", mem_resp_yumi_o, 1'b1);
        reset_i = 1'b1;
        #1;
        chk("midfill_reset_outputs", all_outputs_v(), 7'b0);
        mem_resp_v_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk); #1;
        vecs[0].name = "miss_after_reset";
        run_txn(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
